fpu_bus_sequencer: RTL and testbench

Host-side master for the byte-wide FPU register interface. It accepts floating-point commands from two requesters, arbitrates between them round-robin, and runs the full FPU bus transaction: write operand A, write operand B, write op code, start, wait for cmd_end, read the 4 result bytes, then perform the end_ack handshake. It returns a 32-bit result, or a timeout status, to the requester that was granted. It replaces ad-hoc CPU byte-banging of the FPU and sits between the system fabric and the fpu block.

---
 rtl/fpu_bus_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_fpu_bus_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_bus_sequencer.sv
// Host-side master for the byte-wide FPU register interface: arbitrates two
// requesters round-robin and runs the write/start/wait/read/end_ack sequence.
module fpu_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RD_WAIT        = 1,
  parameter int OP_W           = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [1:0]        req_valid,
  input  logic [63:0]       req_op_a,
  input  logic [63:0]       req_op_b,
  input  logic [2*OP_W-1:0] req_op,
  output logic [1:0]        req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [31:0]       resp_result,
  output logic              resp_timeout,
  output logic [3:0]        fpu_addr,
  output logic [7:0]        fpu_data_out,
  input  logic [7:0]        fpu_data_in,
  output logic              fpu_cs_n,
  output logic              fpu_rd_n,
  output logic              fpu_wr_n,
  output logic              fpu_end_ack,
  input  logic              fpu_cmd_end,
  input  logic              fpu_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(RD_WAIT + 3);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PH_WR_STB  = PW'(1);
  localparam logic [PW-1:0] PH_WR_HOLD = PW'(2);
  localparam logic [PW-1:0] PH_RD_CAP  = PW'(RD_WAIT);
  localparam logic [PW-1:0] PH_RD_REL  = PW'(RD_WAIT + 1);

  typedef enum logic [2:0] {IDLE, WR, WAIT_END, RD, ACK, WAIT_CLR, RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            prio_q, prio_d;
  logic            id_q, id_d;
  logic [31:0]     res_q, res_d;
  logic            to_q, to_d;
  logic [1:0]      rdy_q, rdy_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;

  logic            gnt_any;
  logic            gnt_id;
  logic [7:0]      op_byte;
  logic [7:0]      wr_byte;

  // prio_q names the requester that wins when both are valid
  always_comb begin
    gnt_id = req_valid[1];
    if (req_valid == 2'b11) gnt_id = prio_q;
  end

  assign gnt_any = (state_q == IDLE) && (req_valid != 2'b00) && !fpu_busy;
  assign op_byte = 8'(op_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    tmo_d   = tmo_q;
    prio_d  = prio_q;
    id_d    = id_q;
    res_d   = res_q;
    to_d    = to_q;
    rdy_d   = 2'b00;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          rdy_d   = gnt_id ? 2'b10 : 2'b01;
          id_d    = gnt_id;
          a_d     = gnt_id ? req_op_a[63:32] : req_op_a[31:0];
          b_d     = gnt_id ? req_op_b[63:32] : req_op_b[31:0];
          op_d    = gnt_id ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
          res_d   = '0;
          to_d    = 1'b0;
          idx_d   = '0;
          ph_d    = '0;
          state_d = WR;
        end
      end
      WR: begin
        if (ph_q == PH_WR_HOLD) begin
          ph_d = '0;
          if (idx_q == 4'd9) begin
            idx_d   = '0;
            tmo_d   = '0;
            state_d = WAIT_END;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      WAIT_END: begin
        if (fpu_cmd_end) begin
          idx_d   = '0;
          ph_d    = '0;
          state_d = RD;
        end else if (tmo_q == TMO_LAST) begin
          to_d    = 1'b1;
          res_d   = '0;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RD: begin
        if (ph_q == PH_RD_CAP) res_d[{idx_q[1:0], 3'b000} +: 8] = fpu_data_in;
        if (ph_q == PH_RD_REL) begin
          ph_d = '0;
          if (idx_q == 4'd3) begin
            idx_d   = '0;
            state_d = ACK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ACK: begin
        tmo_d   = '0;
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!fpu_cmd_end) begin
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ph_q    <= '0;
      tmo_q   <= '0;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      res_q   <= '0;
      to_q    <= 1'b0;
      rdy_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      tmo_q   <= tmo_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      res_q   <= res_d;
      to_q    <= to_d;
      rdy_q   <= rdy_d;
    end
  end

  // Captured command operands carry no reset: they are only read after a grant
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  always_comb begin
    wr_byte = 8'h00;
    if (idx_q < 4'd4)       wr_byte = a_q[{idx_q[1:0], 3'b000} +: 8];
    else if (idx_q < 4'd8)  wr_byte = b_q[{idx_q[1:0], 3'b000} +: 8];
    else if (idx_q == 4'd8) wr_byte = op_byte;
  end

  // Bus strobes decode straight from state so an async reset idles them at once
  always_comb begin
    fpu_cs_n     = 1'b1;
    fpu_rd_n     = 1'b1;
    fpu_wr_n     = 1'b1;
    fpu_addr     = 4'h0;
    fpu_data_out = 8'h00;
    fpu_end_ack  = 1'b0;
    case (state_q)
      WR: begin
        fpu_addr     = idx_q;
        fpu_data_out = wr_byte;
        fpu_cs_n     = (ph_q == PH_WR_HOLD);
        fpu_wr_n     = (ph_q != PH_WR_STB);
      end
      RD: begin
        fpu_addr = 4'd9 + idx_q;
        fpu_cs_n = (ph_q == PH_RD_REL);
        fpu_rd_n = (ph_q == PH_RD_REL);
      end
      ACK, WAIT_CLR: fpu_end_ack = 1'b1;
      default: ;
    endcase
  end

  assign req_ready    = rdy_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_id      = id_q;
  assign resp_result  = res_q;
  assign resp_timeout = to_q;

endmodule

// File: tb/tb_fpu_bus_sequencer.sv
// Bench for fpu_bus_sequencer: behavioural FPU register model, a vector table
// of single commands, and directed sequences for arbitration and corner cases.
module tb_fpu_bus_sequencer;
  localparam int TMO = 64;
  localparam int RDW = 1;
  localparam int OPW = 8;
  localparam logic [7:0] OP_ADD = 8'h01;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [63:0] req_op_a = '0;
  logic [63:0] req_op_b = '0;
  logic [15:0] req_op = '0;
  logic [1:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_id;
  logic [31:0] resp_result;
  logic        resp_timeout;
  logic [3:0]  fpu_addr;
  logic [7:0]  fpu_data_out;
  logic [7:0]  fpu_data_in;
  logic        fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack;
  logic        fpu_cmd_end;
  logic        fpu_busy;

  fpu_bus_sequencer #(.TIMEOUT_CYCLES(TMO), .RD_WAIT(RDW), .OP_W(OPW)) dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_op_a(req_op_a),
    .req_op_b(req_op_b), .req_op(req_op), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_timeout(resp_timeout), .fpu_addr(fpu_addr),
    .fpu_data_out(fpu_data_out), .fpu_data_in(fpu_data_in), .fpu_cs_n(fpu_cs_n),
    .fpu_rd_n(fpu_rd_n), .fpu_wr_n(fpu_wr_n), .fpu_end_ack(fpu_end_ack),
    .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // FPU model: registers 0..8, start at addr 9, result bytes at 9..C
  logic [7:0]  m_reg [0:8];
  logic [31:0] m_res = '0;
  logic [1:0]  m_st;
  int          m_cnt;
  logic        m_busy, m_end;
  bit          noend = 1'b0;
  bit          kill = 1'b0;
  int          ack_hold = 1;

  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h43a98fbe, 32'h4426ffdf}: return 32'h447bc7be;
      {32'h42f63efa, 32'h43a6aaa0}: return 32'h43e43a5e;
      {32'h4d96890d, 32'h4a447fad}: return 32'h4d98120c;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_st <= 2'd0; m_busy <= 1'b0; m_end <= 1'b0; m_cnt <= 0;
    end else begin
      if (!fpu_cs_n && !fpu_wr_n && fpu_addr < 4'd9) m_reg[fpu_addr] <= fpu_data_out;
      case (m_st)
        2'd0: if (!fpu_cs_n && !fpu_wr_n && fpu_addr == 4'd9) begin
          m_st <= 2'd1; m_busy <= 1'b1; m_cnt <= 5;
          m_res <= fpu_fn({m_reg[3], m_reg[2], m_reg[1], m_reg[0]},
                          {m_reg[7], m_reg[6], m_reg[5], m_reg[4]});
        end
        2'd1: begin
          if (m_cnt > 1) m_cnt <= m_cnt - 1;
          else if (!noend) begin m_end <= 1'b1; m_busy <= 1'b0; m_st <= 2'd2; end
          else if (kill) begin m_busy <= 1'b0; m_st <= 2'd0; end
        end
        2'd2: if (fpu_end_ack) begin m_cnt <= ack_hold; m_st <= 2'd3; end
        default: begin
          if (m_cnt <= 1) begin m_end <= 1'b0; m_st <= 2'd0; end
          else m_cnt <= m_cnt - 1;
        end
      endcase
    end
  end

  assign fpu_cmd_end = m_end;
  assign fpu_busy    = m_busy;

  always_comb begin
    case (fpu_addr)
      4'h9:    fpu_data_in = m_res[7:0];
      4'hA:    fpu_data_in = m_res[15:8];
      4'hB:    fpu_data_in = m_res[23:16];
      4'hC:    fpu_data_in = m_res[31:24];
      default: fpu_data_in = 8'h00;
    endcase
  end

  // Bus monitor: strobe legality, 3-cycle write framing, read strobe length
  typedef struct packed {logic cs; logic wr; logic rd; logic [3:0] addr; logic [7:0] data;} bus_t;
  localparam bus_t BUS_IDLE = '{cs: 1'b1, wr: 1'b1, rd: 1'b1, addr: 4'h0, data: 8'h00};
  bus_t        cur, p1, p2;
  int          fmt_err = 0, proto_err = 0, ack_cycles = 0, rd_run = 0, last_wr_cyc = 0;
  logic [11:0] wlog [$];

  always @(negedge clk) begin
    cur = '{cs: fpu_cs_n, wr: fpu_wr_n, rd: fpu_rd_n, addr: fpu_addr, data: fpu_data_out};
    if (!arst_n) begin
      p1 = BUS_IDLE; p2 = BUS_IDLE; rd_run = 0;
    end else begin
      if ((!cur.rd && !cur.wr) || ((!cur.rd || !cur.wr) && cur.cs)) proto_err++;
      if (fpu_end_ack) ack_cycles++;
      if (!cur.wr) begin
        wlog.push_back({cur.addr, cur.data});
        last_wr_cyc = cyc;
        if (p1.cs || !p1.wr || p1.addr != cur.addr || p1.data != cur.data || !p2.cs) fmt_err++;
      end
      if (!p1.wr && !(cur.cs && cur.wr && cur.addr == p1.addr && cur.data == p1.data)) fmt_err++;
      if (!cur.rd) rd_run++;
      else begin
        if (rd_run != 0 && rd_run != RDW + 1) fmt_err++;
        rd_run = 0;
      end
      p2 = p1; p1 = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] op);
    if (id) begin req_op_a[63:32] = a; req_op_b[63:32] = b; req_op[15:8] = op; end
    else    begin req_op_a[31:0]  = a; req_op_b[31:0]  = b; req_op[7:0]  = op; end
  endtask

  task automatic wait_ready(output logic [1:0] got, input string name);
    got = 2'b00;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin got = req_ready; return; end
    end
    fail_now({name, "_ready"});
  endtask

  task automatic wait_resp(input string name);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (resp_valid) return;
    end
    fail_now({name, "_resp"});
  endtask

  task automatic ack_resp(input string name);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({name, "_resp_clear"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic run_one(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] op, input logic [31:0] exp, input string name);
    logic [1:0] got;
    @(negedge clk);
    set_req(id, a, b, op);
    req_valid = id ? 2'b10 : 2'b01;
    wait_ready(got, name);
    check({name, "_grant"}, 32'(got), id ? 32'd2 : 32'd1);
    req_valid = 2'b00;
    wait_resp(name);
    check({name, "_id"}, 32'(resp_id), 32'(id));
    check({name, "_result"}, resp_result, exp);
    check({name, "_timeout"}, 32'(resp_timeout), 32'd0);
    ack_resp(name);
  endtask

  typedef struct {logic id; logic [31:0] a; logic [31:0] b; logic [7:0] op; logic [31:0] exp;} vec_t;
  vec_t        vecs [5];
  logic [1:0]  got;
  logic [7:0]  ed;
  logic [31:0] snap_res;
  logic        snap_id, snap_to;
  int          bad_a, bad_b, bad_c, bad_d, t0, t1, t2;

  initial begin
    vecs[0] = '{id: 1'b0, a: 32'h43a98fbe, b: 32'h4426ffdf, op: OP_ADD, exp: 32'h447bc7be};
    vecs[1] = '{id: 1'b1, a: 32'h42f63efa, b: 32'h43a6aaa0, op: OP_ADD, exp: 32'h43e43a5e};
    vecs[2] = '{id: 1'b0, a: 32'h4d96890d, b: 32'h4a447fad, op: OP_ADD, exp: 32'h4d98120c};
    vecs[3] = '{id: 1'b1, a: 32'h12345678, b: 32'h9abcdef0, op: 8'h02,  exp: 32'h88888888};
    vecs[4] = '{id: 1'b0, a: 32'hffffffff, b: 32'h00000000, op: 8'h03,  exp: 32'hffffffff};

    tick(2);
    check("rst_strobes", 32'({fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack}), 32'b1110);
    check("rst_addr_data", 32'({fpu_addr, fpu_data_out}), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp", 32'({resp_valid, resp_id, resp_timeout}), 32'd0);
    check("rst_result", resp_result, 32'd0);
    arst_n = 1'b1;
    tick(2);

    // Contention from reset: req0 first, then alternate while both stay valid
    set_req(1'b0, 32'h42f63efa, 32'h43a6aaa0, OP_ADD);
    set_req(1'b1, 32'h4d96890d, 32'h4a447fad, OP_ADD);
    req_valid = 2'b11;
    wait_ready(got, "cont1");
    check("cont1_grant", 32'(got), 32'd1);
    wait_resp("cont1");
    check("cont1_id", 32'(resp_id), 32'd0);
    check("cont1_result", resp_result, 32'h43e43a5e);
    ack_resp("cont1");
    wait_ready(got, "cont2");
    check("cont2_grant", 32'(got), 32'd2);
    wait_resp("cont2");
    check("cont2_id", 32'(resp_id), 32'd1);
    check("cont2_result", resp_result, 32'h4d98120c);
    ack_resp("cont2");
    wait_ready(got, "cont3");
    check("cont3_grant", 32'(got), 32'd1);
    req_valid = 2'b00;
    wait_resp("cont3");
    check("cont3_id", 32'(resp_id), 32'd0);
    check("cont3_result", resp_result, 32'h43e43a5e);
    ack_resp("cont3");

    for (int v = 0; v < 5; v++) begin
      wlog.delete();
      run_one(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].exp, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_nwrites", v), 32'(wlog.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
        if (i < 4)      ed = vecs[v].a[8*i +: 8];
        else if (i < 8) ed = vecs[v].b[8*(i-4) +: 8];
        else if (i == 8) ed = vecs[v].op;
        else            ed = 8'h00;
        check($sformatf("vec%0d_wr%0d", v, i),
              32'((wlog.size() > i) ? wlog[i] : 12'hfff), 32'({4'(i), ed}));
      end
    end

    // Backpressure: response held, req1 waiting must not be granted
    @(negedge clk);
    set_req(1'b0, 32'h43a98fbe, 32'h4426ffdf, OP_ADD);
    req_valid = 2'b01;
    wait_ready(got, "bp");
    set_req(1'b1, 32'h11111111, 32'h22222222, OP_ADD);
    req_valid = 2'b10;
    wait_resp("bp");
    snap_res = resp_result; snap_id = resp_id; snap_to = resp_timeout;
    bad_a = 0; bad_b = 0; bad_c = 0; bad_d = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!resp_valid) bad_a++;
      if (resp_result !== snap_res || resp_id !== snap_id || resp_timeout !== snap_to) bad_b++;
      if (req_ready != 2'b00) bad_c++;
      if (!(fpu_cs_n && fpu_rd_n && fpu_wr_n && !fpu_end_ack)) bad_d++;
    end
    check("bp_valid_held", 32'(bad_a), 32'd0);
    check("bp_data_stable", 32'(bad_b), 32'd0);
    check("bp_no_grant", 32'(bad_c), 32'd0);
    check("bp_bus_idle", 32'(bad_d), 32'd0);
    check("bp_result", snap_res, 32'h447bc7be);
    ack_resp("bp");
    wait_ready(got, "bp_next");
    check("bp_next_grant", 32'(got), 32'd2);
    req_valid = 2'b00;
    wait_resp("bp_next");
    check("bp_next_result", resp_result, 32'h33333333);
    ack_resp("bp_next");

    // Timeout: cmd_end never rises, busy stays high afterwards
    noend = 1'b1;
    ack_cycles = 0;
    @(negedge clk);
    set_req(1'b0, 32'h01010101, 32'h10101010, OP_ADD);
    req_valid = 2'b01;
    wait_ready(got, "tmo");
    req_valid = 2'b00;
    wait_resp("tmo");
    check("tmo_latency", 32'(cyc - last_wr_cyc), 32'd66);
    check("tmo_flag", 32'(resp_timeout), 32'd1);
    check("tmo_result", resp_result, 32'd0);
    check("tmo_no_end_ack", 32'(ack_cycles), 32'd0);
    set_req(1'b0, 32'h0000ffff, 32'hffff0000, OP_ADD);
    req_valid = 2'b01;
    ack_resp("tmo");
    bad_a = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) bad_a++;
    end
    check("tmo_busy_blocks_grant", 32'(bad_a), 32'd0);
    kill = 1'b1;
    wait_ready(got, "tmo_next");
    check("tmo_next_grant", 32'(got), 32'd1);
    kill = 1'b0;
    noend = 1'b0;
    req_valid = 2'b00;
    wait_resp("tmo_next");
    check("tmo_next_result", resp_result, 32'hffffffff);
    check("tmo_next_timeout", 32'(resp_timeout), 32'd0);
    ack_resp("tmo_next");

    // Reset during the second result byte read
    @(negedge clk);
    set_req(1'b0, 32'h0a0b0c0d, 32'h01020304, OP_ADD);
    req_valid = 2'b01;
    wait_ready(got, "rstrd");
    req_valid = 2'b00;
    bad_a = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!fpu_cs_n && !fpu_rd_n && fpu_addr == 4'hA) begin bad_a = 0; break; end
    end
    check("rstrd_reached_byte2", 32'(bad_a), 32'd0);
    #1 arst_n = 1'b0;
    #1;
    check("rstrd_strobes", 32'({fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack}), 32'b1110);
    check("rstrd_resp_valid", 32'(resp_valid), 32'd0);
    tick(2);
    arst_n = 1'b1;
    bad_a = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid) bad_a++;
    end
    check("rstrd_no_resp", 32'(bad_a), 32'd0);
    run_one(1'b0, 32'h0a0b0c0d, 32'h01020304, OP_ADD, 32'h0b090f09, "rstrd_after");

    // Slow ack: cmd_end held 10 cycles after end_ack
    ack_hold = 10;
    @(negedge clk);
    set_req(1'b1, 32'h42f63efa, 32'h43a6aaa0, OP_ADD);
    req_valid = 2'b10;
    wait_ready(got, "slow");
    req_valid = 2'b00;
    t0 = -1; t1 = -1; t2 = -1; bad_a = 0;
    for (int k = 0; k < 300 && t0 < 0; k++) begin
      @(negedge clk);
      if (fpu_end_ack) t0 = cyc;
    end
    for (int k = 0; k < 300 && t1 < 0; k++) begin
      @(negedge clk);
      if (!fpu_end_ack) bad_a++;
      if (!fpu_cmd_end) t1 = cyc;
    end
    for (int k = 0; k < 10 && t2 < 0; k++) begin
      @(negedge clk);
      if (!fpu_end_ack) t2 = cyc;
    end
    check("slow_ack_held", 32'(bad_a), 32'd0);
    check("slow_ack_long", 32'(t1 - t0 >= 10), 32'd1);
    check("slow_ack_release", 32'(t2 - t1), 32'd1);
    wait_resp("slow");
    check("slow_timeout", 32'(resp_timeout), 32'd0);
    check("slow_result", resp_result, 32'h43e43a5e);
    ack_resp("slow");
    ack_hold = 1;

    check("bus_protocol", 32'(proto_err), 32'd0);
    check("bus_framing", 32'(fmt_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
